// File: rtl/dispatch_issue_if.sv
// Dispatch-to-issue bundle: decoded instruction in with ready, issued fields out with ex_ready.
// master drives the decoded instruction and ex_ready; slave (dispatch_issue) drives ready and issue fields.
interface dispatch_issue_if;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [4:0]  rj_i;
  logic [4:0]  rk_i;
  logic        rj_en_i;
  logic        rk_en_i;
  logic [4:0]  rd_i;
  logic        rd_we_i;
  logic        is_load_i;
  logic        ready_o;

  logic        ex_ready_i;
  logic        issue_valid_o;
  logic [31:0] issue_pc_o;
  logic [4:0]  issue_rd_o;
  logic        issue_rd_we_o;
  logic        issue_is_load_o;

  modport master (
    output valid_i, pc_i, rj_i, rk_i, rj_en_i, rk_en_i, rd_i, rd_we_i, is_load_i, ex_ready_i,
    input  ready_o, issue_valid_o, issue_pc_o, issue_rd_o, issue_rd_we_o, issue_is_load_o
  );

  modport slave (
    input  valid_i, pc_i, rj_i, rk_i, rj_en_i, rk_en_i, rd_i, rd_we_i, is_load_i, ex_ready_i,
    output ready_o, issue_valid_o, issue_pc_o, issue_rd_o, issue_rd_we_o, issue_is_load_o
  );
endinterface

// File: rtl/dispatch_issue.sv
// One-entry hold slot plus load scoreboard; issues at the earliest one edge after acceptance.
// Stalls (ready low, pause high) on register hazards, a full load window, or execute backpressure.
module dispatch_issue #(
  parameter int LOAD_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  dispatch_issue_if.slave  dif,
  input  logic             branch_flush,
  input  logic             exception_flush,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  output logic             pause_req_o
);

  localparam int CW = $clog2(LOAD_MAX + 1);

  logic          hold_valid;
  logic [31:0]   hold_pc;
  logic [4:0]    hold_rj;
  logic [4:0]    hold_rk;
  logic          hold_rj_en;
  logic          hold_rk_en;
  logic [4:0]    hold_rd;
  logic          hold_rd_we;
  logic          hold_is_load;

  logic [31:0]   busy;
  logic [CW-1:0] load_cnt;

  logic [31:0]   wb_mask;
  logic [31:0]   set_mask;
  logic [31:0]   eff_busy;
  logic [31:0]   busy_nxt;
  logic          hazard;
  logic          load_full;
  logic          issue_fire;
  logic          accept;
  logic          fire_upd;
  logic          load_inc;
  logic          load_dec;

  // A writeback landing this cycle already satisfies the dependency (bypass).
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid_i) wb_mask[wb_rd_i] = 1'b1;
    if (fire_upd && hold_is_load && hold_rd_we && (hold_rd != 5'd0)) set_mask[hold_rd] = 1'b1;
    eff_busy    = busy & ~wb_mask;
    busy_nxt    = (busy & ~wb_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  assign hazard = hold_valid && ((hold_rj_en && eff_busy[hold_rj]) ||
                                 (hold_rk_en && eff_busy[hold_rk]) ||
                                 (hold_rd_we && eff_busy[hold_rd]));

  assign load_full  = hold_is_load && (load_cnt == CW'(LOAD_MAX)) && !wb_valid_i;
  assign issue_fire = hold_valid && !hazard && !load_full && (!dif.issue_valid_o || dif.ex_ready_i);

  assign dif.ready_o = !hold_valid || issue_fire;
  assign pause_req_o = hold_valid && (hazard || load_full || (dif.issue_valid_o && !dif.ex_ready_i));

  // A flushed issue never reaches execute, so it must not claim a scoreboard slot.
  assign accept   = dif.valid_i && dif.ready_o && !branch_flush && !exception_flush;
  assign fire_upd = issue_fire && !branch_flush && !exception_flush;
  assign load_inc = fire_upd && hold_is_load;
  assign load_dec = wb_valid_i && (load_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid          <= 1'b0;
      hold_pc             <= '0;
      hold_rj             <= '0;
      hold_rk             <= '0;
      hold_rj_en          <= 1'b0;
      hold_rk_en          <= 1'b0;
      hold_rd             <= '0;
      hold_rd_we          <= 1'b0;
      hold_is_load        <= 1'b0;
      dif.issue_valid_o   <= 1'b0;
      dif.issue_pc_o      <= '0;
      dif.issue_rd_o      <= '0;
      dif.issue_rd_we_o   <= 1'b0;
      dif.issue_is_load_o <= 1'b0;
      busy                <= '0;
      load_cnt            <= '0;
    end else if (exception_flush) begin
      hold_valid        <= 1'b0;
      dif.issue_valid_o <= 1'b0;
      busy              <= '0;
      load_cnt          <= '0;
    end else begin
      if (branch_flush) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid   <= 1'b1;
        hold_pc      <= dif.pc_i;
        hold_rj      <= dif.rj_i;
        hold_rk      <= dif.rk_i;
        hold_rj_en   <= dif.rj_en_i;
        hold_rk_en   <= dif.rk_en_i;
        hold_rd      <= dif.rd_i;
        hold_rd_we   <= dif.rd_we_i;
        hold_is_load <= dif.is_load_i;
      end else if (issue_fire) begin
        hold_valid <= 1'b0;
      end

      if (branch_flush) begin
        dif.issue_valid_o <= 1'b0;
      end else if (issue_fire) begin
        dif.issue_valid_o   <= 1'b1;
        dif.issue_pc_o      <= hold_pc;
        dif.issue_rd_o      <= hold_rd;
        dif.issue_rd_we_o   <= hold_rd_we;
        dif.issue_is_load_o <= hold_is_load;
      end else if (dif.issue_valid_o && dif.ex_ready_i) begin
        dif.issue_valid_o <= 1'b0;
      end

      busy <= busy_nxt;
      case ({load_inc, load_dec})
        2'b10:   load_cnt <= load_cnt + 1'b1;
        2'b01:   load_cnt <= load_cnt - 1'b1;
        default: load_cnt <= load_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_issue.sv
// Bench for dispatch_issue: PC scoreboard on the issue port plus directed hazard/flush/reset checks.
module tb_dispatch_issue;
  logic       clk = 1'b0;
  logic       rst;
  logic       branch_flush;
  logic       exception_flush;
  logic       wb_valid_i;
  logic [4:0] wb_rd_i;
  logic       pause_req_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  dispatch_issue_if dif ();

  dispatch_issue #(.LOAD_MAX(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .dif             (dif.slave),
    .branch_flush    (branch_flush),
    .exception_flush (exception_flush),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_i         (wb_rd_i),
    .pause_req_o     (pause_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [4:0] rj, input logic rj_en,
                     input logic [4:0] rd, input logic ld);
    dif.valid_i   = 1'b1;
    dif.pc_i      = pc;
    dif.rj_i      = rj;
    dif.rj_en_i   = rj_en;
    dif.rk_i      = 5'd0;
    dif.rk_en_i   = 1'b0;
    dif.rd_i      = rd;
    dif.rd_we_i   = 1'b1;
    dif.is_load_i = ld;
  endtask

  task automatic idle();
    dif.valid_i = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    wb_valid_i = v;
    wb_rd_i    = r;
  endtask

  // Handshakes are stable at the falling edge; they take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst || branch_flush || exception_flush) begin
      exp_q.delete();
    end else begin
      if (dif.issue_valid_o && dif.ex_ready_i) begin
        if (exp_q.size() == 0) chk("sb_underflow", dif.issue_pc_o, 32'hffff_ffff);
        else chk("sb_pc", dif.issue_pc_o, exp_q.pop_front());
      end
      if (dif.valid_i && dif.ready_o) exp_q.push_back(dif.pc_i);
    end
  end

  initial begin
    rst = 1'b0;
    branch_flush = 1'b0;
    exception_flush = 1'b0;
    wb(1'b0, 5'd0);
    idle();
    put(32'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    dif.ex_ready_i = 1'b1;
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(dif.ready_o), 32'd1);
    chk("rst_pause", 32'(pause_req_o), 32'd0);
    chk("rst_iv", 32'(dif.issue_valid_o), 32'd0);
    chk("rst_busy", dut.busy, 32'd0);
    rst = 1'b0;
    tick();

    // Independent ALU stream: one issue per cycle once the pipe fills.
    for (int i = 0; i < 6; i++) begin
      put(32'd100 + 32'(4 * i), 5'd0, 1'b0, 5'(10 + i), 1'b0);
      #1;
      chk("stream_pause", 32'(pause_req_o), 32'd0);
      chk("stream_ready", 32'(dif.ready_o), 32'd1);
      chk("stream_iv", 32'(dif.issue_valid_o), (i >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();
    tick();

    // Load r5 then dependent add; writeback releases the add via bypass.
    put(32'd200, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    put(32'd204, 5'd5, 1'b1, 5'd6, 1'b0);
    tick();
    idle();
    #1 chk("raw_pause0", 32'(pause_req_o), 32'd1);
    tick();
    chk("raw_pause1", 32'(pause_req_o), 32'd1);
    chk("raw_busy5", 32'(dut.busy[5]), 32'd1);
    tick();
    chk("raw_pause2", 32'(pause_req_o), 32'd1);
    wb(1'b1, 5'd5);
    #1 chk("raw_bypass_pause", 32'(pause_req_o), 32'd0);
    tick();
    wb(1'b0, 5'd0);
    chk("raw_issue_iv", 32'(dif.issue_valid_o), 32'd1);
    chk("raw_issue_pc", dif.issue_pc_o, 32'd204);
    chk("raw_busy5_clr", 32'(dut.busy[5]), 32'd0);
    chk("raw_cnt", 32'(dut.load_cnt), 32'd0);
    tick();

    // Three loads with LOAD_MAX=2: the third waits for a writeback.
    put(32'd300, 5'd0, 1'b0, 5'd1, 1'b1);
    tick();
    put(32'd304, 5'd0, 1'b0, 5'd2, 1'b1);
    tick();
    put(32'd308, 5'd0, 1'b0, 5'd3, 1'b1);
    tick();
    idle();
    #1;
    chk("lmax_pause", 32'(pause_req_o), 32'd1);
    chk("lmax_ready", 32'(dif.ready_o), 32'd0);
    chk("lmax_cnt", 32'(dut.load_cnt), 32'd2);
    tick();
    chk("lmax_still", 32'(pause_req_o), 32'd1);
    wb(1'b1, 5'd1);
    #1 chk("lmax_release", 32'(pause_req_o), 32'd0);
    tick();
    wb(1'b0, 5'd0);
    chk("lmax_issue_pc", dif.issue_pc_o, 32'd308);
    chk("lmax_cnt_eq", 32'(dut.load_cnt), 32'd2);
    chk("lmax_busy", dut.busy & 32'hE, 32'hC);
    wb(1'b1, 5'd2);
    tick();
    wb(1'b1, 5'd3);
    tick();
    wb(1'b0, 5'd0);
    chk("lmax_drain_cnt", 32'(dut.load_cnt), 32'd0);

    // Load r7 issuing in the same cycle r7 writes back: set wins, count unchanged.
    put(32'd400, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    put(32'd404, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    idle();
    #1;
    chk("setclr_pause", 32'(pause_req_o), 32'd1);
    chk("setclr_cnt0", 32'(dut.load_cnt), 32'd1);
    wb(1'b1, 5'd7);
    tick();
    wb(1'b0, 5'd0);
    chk("setclr_busy7", 32'(dut.busy[7]), 32'd1);
    chk("setclr_cnt", 32'(dut.load_cnt), 32'd1);
    chk("setclr_pc", dif.issue_pc_o, 32'd404);
    wb(1'b1, 5'd7);
    tick();
    wb(1'b0, 5'd0);
    chk("setclr_drain", 32'(dut.load_cnt), 32'd0);

    // Flushes with both slots full and r4 busy.
    dif.ex_ready_i = 1'b0;
    put(32'd500, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    put(32'd504, 5'd0, 1'b0, 5'd20, 1'b0);
    tick();
    idle();
    #1;
    chk("bf_pre_iv", 32'(dif.issue_valid_o), 32'd1);
    chk("bf_pre_pause", 32'(pause_req_o), 32'd1);
    branch_flush = 1'b1;
    tick();
    branch_flush = 1'b0;
    chk("bf_iv", 32'(dif.issue_valid_o), 32'd0);
    chk("bf_ready", 32'(dif.ready_o), 32'd1);
    chk("bf_busy4", 32'(dut.busy[4]), 32'd1);
    chk("bf_cnt", 32'(dut.load_cnt), 32'd1);
    exception_flush = 1'b1;
    tick();
    exception_flush = 1'b0;
    chk("xf_busy", dut.busy, 32'd0);
    chk("xf_cnt", 32'(dut.load_cnt), 32'd0);
    dif.ex_ready_i = 1'b1;
    tick();

    // Asynchronous reset while stalled.
    put(32'd600, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    put(32'd604, 5'd9, 1'b1, 5'd10, 1'b0);
    tick();
    idle();
    #1;
    chk("ar_pre_pause", 32'(pause_req_o), 32'd1);
    chk("ar_pre_iv", 32'(dif.issue_valid_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_pause", 32'(pause_req_o), 32'd0);
    chk("ar_ready", 32'(dif.ready_o), 32'd1);
    chk("ar_iv", 32'(dif.issue_valid_o), 32'd0);
    chk("ar_pc", dif.issue_pc_o, 32'd0);
    chk("ar_cnt", 32'(dut.load_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dispatch_issue.md
DISPATCH_ISSUE -- requirements
Module: dispatch_issue

Interface
REQ-001 Parameter LOAD_MAX, default 2: maximum outstanding loads.
REQ-002 clk  in  1: single clock; all state updates on rising edge.
REQ-003 rst  in  1: reset, asynchronous, active-high.
REQ-004 valid_i  in  1: decoded instruction presented by the ID/dispatch register.
REQ-005 pc_i  in  32: instruction PC.
REQ-006 rj_i, rk_i  in  5 each: source register indices.
REQ-007 rj_en_i, rk_en_i  in  1 each: source read enables.
REQ-008 rd_i  in  5: destination index; rd_we_i  in  1: destination write enable.
REQ-009 is_load_i  in  1: instruction is a load.
REQ-010 branch_flush  in  1: discard younger, unissued work.
REQ-011 exception_flush  in  1: discard all state.
REQ-012 ex_ready_i  in  1: execute stage accepts the output register this cycle.
REQ-013 wb_valid_i  in  1: load writeback strobe; wb_rd_i  in  5: its destination.
REQ-014 ready_o  out  1: hold slot can accept valid_i this cycle.
REQ-015 issue_valid_o  out  1: output register holds an issued instruction.
REQ-016 issue_pc_o  out  32; issue_rd_o  out  5; issue_rd_we_o  out  1; issue_is_load_o  out  1: registered issued fields.
REQ-017 pause_req_o  out  1: stall request to the pipeline controller.

Function
REQ-018 Hold register: one entry (valid bit plus all input fields); accept when valid_i && ready_o.
REQ-019 ready_o = !hold_valid || issue_fire, combinational.
REQ-020 Scoreboard: 32 busy bits; busy[0] is constantly 0.
REQ-021 Effective busy: busy[r] && !(wb_valid_i && wb_rd_i==r), i.e. same-cycle writeback bypass.
REQ-022 hazard = hold_valid && ((rj_en && eff_busy[rj]) || (rk_en && eff_busy[rk]) || (rd_we && eff_busy[rd])).
REQ-023 load_full = hold is_load && load_cnt==LOAD_MAX && !wb_valid_i.
REQ-024 issue_fire = hold_valid && !hazard && !load_full && (!issue_valid_o || ex_ready_i).
REQ-025 On issue_fire, the output register loads the hold fields and sets issue_valid_o=1; hold_valid clears unless refilled in the same cycle.
REQ-026 If issue_valid_o && ex_ready_i && !issue_fire, issue_valid_o clears; otherwise the output register holds.
REQ-027 On issue_fire of a load with rd_we and rd!=0, busy[rd] is set; load_cnt increments.
REQ-028 On wb_valid_i, busy[wb_rd_i] clears and load_cnt decrements (saturating at 0).
REQ-029 If a set and a clear target the same register in the same cycle, the set wins; simultaneous increment and decrement leave load_cnt unchanged.
REQ-030 pause_req_o = hold_valid && (hazard || load_full || (issue_valid_o && !ex_ready_i)), combinational.
REQ-031 Latency: an instruction accepted at edge N appears on issue_valid_o after edge N+1 at the earliest.
REQ-032 branch_flush clears hold_valid and issue_valid_o and blocks acceptance that cycle; scoreboard and load_cnt are kept, because older loads still write back.
REQ-033 exception_flush clears hold_valid, issue_valid_o, all busy bits and load_cnt, and overrides branch_flush and every other update that cycle.

Reset
REQ-034 While rst=1: hold_valid=0, issue_valid_o=0, issue fields=0, busy=0, load_cnt=0.
REQ-035 Consequently, while rst=1: ready_o=1 and pause_req_o=0.
REQ-036 Reset asserted mid-operation discards all in-flight state immediately, without waiting for a clock edge.

Verification
REQ-037 Independent ALU ops stream, ex_ready_i=1 -> one issue per cycle, pause_req_o=0, PCs in order.
REQ-038 Load r5, then add reading r5; wb_valid_i (wb_rd_i=5) 3 cycles later -> add is held with pause_req_o=1 until the wb cycle and issues at that edge via bypass.
REQ-039 Three back-to-back loads to r1, r2, r3 with LOAD_MAX=2 and no writeback -> third load stalls with load_cnt=2; issues at the edge that samples wb_valid_i.
REQ-040 Load r7 issuing in the same cycle as wb_valid_i for r7 -> busy[7]=1 afterwards and load_cnt unchanged.
REQ-041 branch_flush with hold and output valid and busy[4]=1 -> both valids 0 next cycle and busy[4] still 1; exception_flush -> busy all 0 and load_cnt=0.
REQ-042 rst pulse asserted between edges while pause_req_o=1 -> outputs drop to reset values immediately, without a clock edge.
